// File: rtl/sort_status_if.sv
// sort_status_if: controller-facing command/status bundle for sort_status_unit.
interface sort_status_if #(
  parameter int PASS_W = 4,
  parameter int SWAP_W = 8
);
  logic              start;
  logic              swap;
  logic              pass_end;
  logic              busy;
  logic              sorted;
  logic              abort;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;
  logic [SWAP_W-1:0] swap_cnt;
  modport master (
    output start, swap, pass_end,
    input  busy, sorted, abort, done, pass_cnt, swap_cnt
  );
  modport slave (
    input  start, swap, pass_end,
    output busy, sorted, abort, done, pass_cnt, swap_cnt
  );
endinterface

// File: rtl/sort_status_unit.sv
// sort_status_unit: per-pass swap tracking for a bubble-sort datapath,
// flagging sorted after a swap-free pass or abort when the pass budget runs out.
module sort_status_unit #(
  parameter int MAX_PASS = 8,
  parameter int PASS_W   = $clog2(MAX_PASS + 1),
  parameter int SWAP_W   = 8
) (
  input logic         i_clk,
  input logic         i_rst_n,
  sort_status_if.slave s
);
  typedef enum logic [1:0] {IDLE, RUN, SORTED_S, ABORT_S} state_t;
  state_t            r_state, w_next;
  logic              r_swap_seen, r_done;
  logic [PASS_W-1:0] r_pass_cnt;
  logic [SWAP_W-1:0] r_swap_cnt;
  logic              w_run, w_pass_free, w_last;
  // a swap coincident with pass_end belongs to the pass that is ending
  assign w_run       = r_state == RUN;
  assign w_pass_free = !r_swap_seen && !s.swap;
  assign w_last      = r_pass_cnt == PASS_W'(MAX_PASS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_swap_seen <= 1'b0;
      r_done      <= 1'b0;
      r_pass_cnt  <= '0;
      r_swap_cnt  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= !s.start && w_run && w_next != RUN;
      if (s.start) begin
        r_swap_seen <= 1'b0;
        r_pass_cnt  <= '0;
        r_swap_cnt  <= '0;
      end else if (w_run) begin
        r_swap_seen <= s.pass_end ? 1'b0 : (r_swap_seen | s.swap);
        if (s.swap && !(&r_swap_cnt)) r_swap_cnt <= r_swap_cnt + 1'b1;
        if (s.pass_end) r_pass_cnt <= r_pass_cnt + 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (s.start) w_next = RUN;
    else if (w_run && s.pass_end) w_next = w_pass_free ? SORTED_S : (w_last ? ABORT_S : RUN);
  end
  always_comb begin
    s.busy     = w_run;
    s.sorted   = r_state == SORTED_S;
    s.abort    = r_state == ABORT_S;
    s.done     = r_done;
    s.pass_cnt = r_pass_cnt;
    s.swap_cnt = r_swap_cnt;
  end
endmodule

// File: tb/tb_sort_status_unit.sv
// tb_sort_status_unit: directed checks of sort_status_unit with MAX_PASS=4, SWAP_W=2.
module tb_sort_status_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  sort_status_if #(.PASS_W(3), .SWAP_W(2)) bus ();
  sort_status_unit #(.MAX_PASS(4), .PASS_W(3), .SWAP_W(2)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .s(bus)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic st, input logic sw, input logic pe);
    bus.start = st;
    bus.swap = sw;
    bus.pass_end = pe;
    @(negedge clk);
  endtask
  task automatic expect_out(input string tag, input logic b, input logic so, input logic ab,
                            input logic dn, input logic [2:0] pc, input logic [1:0] sc);
    logic [8:0] obs, exp;
    obs = {bus.busy, bus.sorted, bus.abort, bus.done, bus.pass_cnt, bus.swap_cnt};
    exp = {b, so, ab, dn, pc, sc};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got busy/sorted/abort/done/pass/swap=%b_%b_%b_%b_%0d_%0d exp=%b_%b_%b_%b_%0d_%0d",
             tag, obs[8], obs[7], obs[6], obs[5], obs[4:2], obs[1:0],
             b, so, ab, dn, pc, sc);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.swap = 1'b0;
    bus.pass_end = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 1, 1);
    expect_out("idle_ignore", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0);
    expect_out("start_run", 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 1);
    expect_out("sorted_first", 0, 1, 0, 1, 1, 0);
    cyc(0, 0, 0);
    expect_out("done_one_cycle", 0, 1, 0, 0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    expect_out("three_swaps", 1, 0, 0, 0, 0, 3);
    cyc(0, 0, 1);
    expect_out("pass1_dirty", 1, 0, 0, 0, 1, 3);
    cyc(0, 0, 1);
    expect_out("pass2_clean", 0, 1, 0, 1, 2, 3);
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    expect_out("abort_p1", 1, 0, 0, 0, 1, 1);
    cyc(0, 1, 1); cyc(0, 1, 1);
    expect_out("abort_p3", 1, 0, 0, 0, 3, 3);
    cyc(0, 1, 1);
    expect_out("abort_p4", 0, 0, 1, 1, 4, 3);
    cyc(0, 1, 1);
    expect_out("abort_hold1", 0, 0, 1, 0, 4, 3);
    cyc(0, 1, 0);
    expect_out("abort_hold2", 0, 0, 1, 0, 4, 3);
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(0, 0, 1);
    expect_out("last_pass_sorted", 0, 1, 0, 1, 4, 3);
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    expect_out("coincident", 1, 0, 0, 0, 1, 1);
    cyc(0, 0, 1);
    expect_out("coincident_next", 0, 1, 0, 1, 2, 1);
    cyc(0, 1, 1);
    expect_out("sorted_hold", 0, 1, 0, 0, 2, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);
    expect_out("swap_two", 1, 0, 0, 0, 0, 2);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    expect_out("swap_sat", 1, 0, 0, 0, 0, 3);
    cyc(1, 0, 1);
    expect_out("restart_prio", 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    expect_out("restart_nodone", 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0);
    expect_out("pre_async", 1, 0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 1);
    expect_out("post_reset_ignore", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0);
    expect_out("post_reset_start", 1, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sort_status_unit.md
Name: sort_status_unit

Overview:
- Parametrised successor to the single-bit sorted flag.
- Tracks a bubble-sort style datapath pass by pass:
  - records whether any swap occurred in the current pass;
  - counts passes and total swaps;
  - declares the array sorted after a full pass with no swaps;
  - aborts if the pass budget is exhausted.
- Sits beside the sort datapath. The sort controller drives START/SWAP/PASS_END and reads SORTED/ABORT/DONE.

Parameters:
- MAX_PASS, 8, maximum passes allowed before abort (must be ≥1).
- PASS_W, $clog2(MAX_PASS+1), width of the pass counter.
- SWAP_W, 8, width of the saturating total-swap counter.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  begin a new sort; synchronous clear of all tracking state
- SWAP  in  1  datapath performed a swap this cycle
- PASS_END  in  1  this cycle is the last compare of the current pass
- BUSY  out  1  tracking a sort in progress
- SORTED  out  1  sticky: last completed pass had zero swaps
- ABORT  out  1  sticky: MAX_PASS passes completed without a swap-free pass
- DONE  out  1  one-cycle pulse on entry to SORTED or ABORT
- PASS_CNT  out  PASS_W  completed passes in current sort
- SWAP_CNT  out  SWAP_W  total swaps in current sort, saturating

Behaviour:
- Reset (RST_N=0, asynchronous, any state, mid-pass included):
  - state=IDLE;
  - BUSY, SORTED, ABORT, DONE, PASS_CNT, SWAP_CNT, internal swap_seen all 0.
- All outputs are registered. Each takes effect on the clock edge after the causing input; no combinational input-to-output paths.
- States: IDLE, RUN, SORTED_S, ABORT_S. BUSY=1 only in RUN. SORTED=1 only in SORTED_S. ABORT=1 only in ABORT_S.
- START priority: START=1 in any state has priority over SWAP and PASS_END in the same cycle.
  - Next state RUN.
  - PASS_CNT=0, SWAP_CNT=0, swap_seen=0, DONE=0.
  - Restarting while in RUN is legal and discards progress.
- IDLE, SORTED_S, ABORT_S:
  - SWAP and PASS_END are ignored.
  - Counters and flags hold.
- RUN, SWAP=1:
  - swap_seen<=1.
  - SWAP_CNT increments, holding at 2^SWAP_W-1 when saturated.
- RUN, PASS_END=1:
  - PASS_CNT increments.
  - The pass is swap-free iff swap_seen=0 AND SWAP=0 in that cycle. A SWAP coincident with PASS_END belongs to the ending pass.
  - Swap-free pass -> SORTED_S, DONE=1 for one cycle.
  - Otherwise, if the new PASS_CNT equals MAX_PASS -> ABORT_S, DONE=1 for one cycle.
  - Otherwise stay in RUN, swap_seen<=0.
  - If the MAX_PASS-th pass is swap-free, SORTED wins over ABORT.
- PASS_CNT never exceeds MAX_PASS; there is no wrap-around.
- SORTED and ABORT stay sticky until START or reset. They are never both 1.
- DONE is high exactly one cycle per terminal entry and never in IDLE or RUN.

Test Plan:
- Reset, then pulse START; no SWAP; PASS_END on cycle 5 -> one cycle later SORTED=1, DONE=1 for one cycle, PASS_CNT=1, SWAP_CNT=0, BUSY=0.
- START; pass 1 with 3 SWAPs, PASS_END; pass 2 with 0 swaps, PASS_END -> SORTED=1, PASS_CNT=2, SWAP_CNT=3.
- MAX_PASS=4; every pass contains ≥1 SWAP -> after the 4th PASS_END: ABORT=1, DONE pulse, PASS_CNT=4, SORTED=0.
- Further SWAP/PASS_END after termination -> all outputs unchanged.
- SWAP and PASS_END in the same cycle, with no prior swaps in that pass -> not sorted; stays in RUN, PASS_CNT=1, SWAP_CNT=1.
  - The next pass with no swaps -> SORTED=1, PASS_CNT=2.
- SWAP_W=2: 5 swaps -> SWAP_CNT saturates at 3.
  - Then START together with PASS_END -> restart in RUN: counters 0, no DONE.
- Assert RST_N=0 asynchronously mid-RUN, between clock edges -> all outputs 0 immediately.
  - After release, SWAP/PASS_END are ignored until START.
